// File: rtl/game_set_sequencer_if.sv
// rtl/game_set_sequencer_if.sv - pixel bus between raster/mappers and the GAME SET sequencer
interface game_set_sequencer_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic [3:0] banner_r;
  logic [3:0] banner_g;
  logic [3:0] banner_b;
  logic [3:0] scene_r;
  logic [3:0] scene_g;
  logic [3:0] scene_b;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (
    output DrawX, DrawY, blank,
    output banner_r, banner_g, banner_b,
    output scene_r, scene_g, scene_b,
    input  red, green, blue
  );

  modport slave (
    input  DrawX, DrawY, blank,
    input  banner_r, banner_g, banner_b,
    input  scene_r, scene_g, scene_b,
    output red, green, blue
  );
endinterface

// File: rtl/game_set_sequencer.sv
// rtl/game_set_sequencer.sv - GAME SET banner blink/hold sequencer and final pixel mux
module game_set_sequencer #(
  parameter logic [9:0]  FRAME_Y      = 10'd480,
  parameter int          BLINK_FRAMES = 15,
  parameter int          NUM_BLINKS   = 3,
  parameter int          HOLD_FRAMES  = 120,
  parameter logic [11:0] KEY_RGB      = 12'hF0F
) (
  input  logic                       vga_clk,
  input  logic                       reset_n,
  game_set_sequencer_if.slave        pix,
  input  logic                       game_over,
  input  logic                       restart,
  output logic                       seq_busy,
  output logic                       seq_done,
  output logic                       banner_vis
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ON    = 3'd2;
  localparam logic [2:0] S_OFF   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] PAIRS_LAST = 8'(NUM_BLINKS - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [7:0]  frm_cnt;
  logic [7:0]  frm_nxt;
  logic [7:0]  blink_cnt;
  logic [7:0]  blink_nxt;
  logic        done_nxt;
  logic        go_q;
  logic        tick;
  logic        start;
  logic [11:0] banner_rgb;
  logic [11:0] scene_rgb;

  assign tick       = (pix.DrawX == 10'd0) && (pix.DrawY == FRAME_Y);
  assign start      = game_over & ~go_q;
  assign banner_rgb = {pix.banner_r, pix.banner_g, pix.banner_b};
  assign scene_rgb  = {pix.scene_r, pix.scene_g, pix.scene_b};

  always_comb begin
    state_nxt = state;
    frm_nxt   = frm_cnt;
    blink_nxt = blink_cnt;
    done_nxt  = 1'b0;
    if (restart) begin
      state_nxt = S_IDLE;
      frm_nxt   = 8'd0;
      blink_nxt = 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_WAIT;
            frm_nxt   = 8'd0;
            blink_nxt = 8'd0;
          end
        end
        S_WAIT: begin
          if (tick) begin
            state_nxt = S_ON;
            frm_nxt   = 8'd0;
            blink_nxt = 8'd0;
          end
        end
        S_ON: begin
          if (tick) begin
            if (frm_cnt == BLINK_LAST) begin
              state_nxt = S_OFF;
              frm_nxt   = 8'd0;
            end else begin
              frm_nxt = frm_cnt + 8'd1;
            end
          end
        end
        S_OFF: begin
          if (tick) begin
            if (frm_cnt == BLINK_LAST) begin
              frm_nxt = 8'd0;
              if (blink_cnt == PAIRS_LAST) begin
                state_nxt = S_HOLD;
              end else begin
                state_nxt = S_ON;
                blink_nxt = blink_cnt + 8'd1;
              end
            end else begin
              frm_nxt = frm_cnt + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (tick) begin
            if (frm_cnt == HOLD_LAST) begin
              state_nxt = S_DONE;
              frm_nxt   = 8'd0;
              done_nxt  = 1'b1;
            end else begin
              frm_nxt = frm_cnt + 8'd1;
            end
          end
        end
        S_DONE: begin
        end
        default: begin
          state_nxt = S_IDLE;
          frm_nxt   = 8'd0;
          blink_nxt = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      frm_cnt    <= 8'd0;
      blink_cnt  <= 8'd0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      banner_vis <= 1'b0;
    end else begin
      state      <= state_nxt;
      frm_cnt    <= frm_nxt;
      blink_cnt  <= blink_nxt;
      seq_busy   <= (state_nxt == S_WAIT) || (state_nxt == S_ON) ||
                    (state_nxt == S_OFF)  || (state_nxt == S_HOLD);
      seq_done   <= done_nxt;
      banner_vis <= (state_nxt == S_ON) || (state_nxt == S_HOLD) || (state_nxt == S_DONE);
    end
  end

  // go_q keeps tracking through reset so a level held across reset is not an edge
  always_ff @(posedge vga_clk) begin
    go_q <= game_over;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      pix.red   <= 4'd0;
      pix.green <= 4'd0;
      pix.blue  <= 4'd0;
    end else if (!pix.blank) begin
      pix.red   <= 4'd0;
      pix.green <= 4'd0;
      pix.blue  <= 4'd0;
    end else if (banner_vis && (banner_rgb != KEY_RGB)) begin
      pix.red   <= pix.banner_r;
      pix.green <= pix.banner_g;
      pix.blue  <= pix.banner_b;
    end else begin
      pix.red   <= pix.scene_r;
      pix.green <= pix.scene_g;
      pix.blue  <= pix.scene_b;
    end
  end

endmodule
